// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of the three requester ports and the RAM port of
// the shared-RAM arbiter.
//   Loader port      : i_ld_req, i_ld_addr, i_ld_wr, i_ld_wdata -> o_ld_ack, o_ld_rdata
//   CPU data port    : i_d_req,  i_d_addr,  i_d_wr,  i_d_wdata  -> o_d_ack,  o_d_rdata
//   CPU instr port   : i_i_req,  i_i_addr                       -> o_i_ack,  o_i_rdata
//   Boot hold        : i_ld_hold (blocks D and I grants)
//   RAM port         : o_ram_en, o_ram_addr, o_ram_wr, o_ram_wdata <- i_ram_rdata
//   Status           : o_busy
// Handshake: a requester raises req with addr/wr/wdata and holds them stable
// until its ack; ack is a single-cycle pulse one cycle after the grant and
// rdata is only meaningful (non-zero) in that ack cycle. Dropping req in the
// ack cycle is allowed; holding it is a new request.
// modport slave is the arbiter side, modport master the requester/RAM side.
interface ram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic            i_ld_req;
  logic [AW-1:0]   i_ld_addr;
  logic [DW/8-1:0] i_ld_wr;
  logic [DW-1:0]   i_ld_wdata;
  logic            o_ld_ack;
  logic [DW-1:0]   o_ld_rdata;

  logic            i_d_req;
  logic [AW-1:0]   i_d_addr;
  logic [DW/8-1:0] i_d_wr;
  logic [DW-1:0]   i_d_wdata;
  logic            o_d_ack;
  logic [DW-1:0]   o_d_rdata;

  logic            i_i_req;
  logic [AW-1:0]   i_i_addr;
  logic            o_i_ack;
  logic [DW-1:0]   o_i_rdata;

  logic            i_ld_hold;

  logic            o_ram_en;
  logic [AW-1:0]   o_ram_addr;
  logic [DW/8-1:0] o_ram_wr;
  logic [DW-1:0]   o_ram_wdata;
  logic [DW-1:0]   i_ram_rdata;

  logic            o_busy;

  modport slave (
    input  i_ld_req, i_ld_addr, i_ld_wr, i_ld_wdata,
    output o_ld_ack, o_ld_rdata,
    input  i_d_req, i_d_addr, i_d_wr, i_d_wdata,
    output o_d_ack, o_d_rdata,
    input  i_i_req, i_i_addr,
    output o_i_ack, o_i_rdata,
    input  i_ld_hold,
    output o_ram_en, o_ram_addr, o_ram_wr, o_ram_wdata,
    input  i_ram_rdata,
    output o_busy
  );

  modport master (
    output i_ld_req, i_ld_addr, i_ld_wr, i_ld_wdata,
    input  o_ld_ack, o_ld_rdata,
    output i_d_req, i_d_addr, i_d_wr, i_d_wdata,
    input  o_d_ack, o_d_rdata,
    output i_i_req, i_i_addr,
    input  o_i_ack, o_i_rdata,
    output i_ld_hold,
    input  o_ram_en, o_ram_addr, o_ram_wr, o_ram_wdata,
    output i_ram_rdata,
    input  o_busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- three-port arbiter in front of one single-port synchronous
// RAM (read data one cycle after enable).
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-low reset
//   bus         : ram_arbiter_if.slave (loader, CPU data, CPU instr, RAM port)
//   o_dbg_state : FSM state, 0 = IDLE (no ack pending), 1 = ACK (ack pending)
// Grant is combinational on the current requests and drives the RAM port in
// the same cycle. Loader has fixed top priority; D and I share round-robin.
// A port whose ack is being issued this cycle is not eligible, so a req held
// through its ack is re-granted at the earliest one cycle later, while
// another port can use the RAM in that ack cycle.
module ram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ram_arbiter_if.slave    bus,
  output logic            o_dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_L    = 2'd1,
    PORT_D    = 2'd2,
    PORT_I    = 2'd3
  } port_t;

  state_t state;
  port_t  ack_port;   // port whose ack is issued while state == ST_ACK
  port_t  grant;
  logic   rr_last_i;  // 1: I won the last D/I grant, so D wins the next tie
  logic   ld_ack_q;
  logic   d_ack_q;
  logic   i_ack_q;

  logic l_ok;
  logic d_ok;
  logic i_ok;

  // Grant selection. Gated by i_rst so nothing reaches the RAM while reset
  // is asserted.
  always_comb begin
    l_ok  = i_rst && bus.i_ld_req
            && !(state == ST_ACK && ack_port == PORT_L);
    d_ok  = i_rst && bus.i_d_req && !bus.i_ld_hold
            && !(state == ST_ACK && ack_port == PORT_D);
    i_ok  = i_rst && bus.i_i_req && !bus.i_ld_hold
            && !(state == ST_ACK && ack_port == PORT_I);
    grant = PORT_NONE;
    if (l_ok)
      grant = PORT_L;
    else if (d_ok && i_ok)
      grant = rr_last_i ? PORT_D : PORT_I;
    else if (d_ok)
      grant = PORT_D;
    else if (i_ok)
      grant = PORT_I;
  end

  // RAM port mux; all zero when nothing is granted. The instruction port is
  // read-only so it never drives write enables or write data.
  always_comb begin
    bus.o_ram_en    = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wr    = '0;
    bus.o_ram_wdata = '0;
    case (grant)
      PORT_L: begin
        bus.o_ram_en    = 1'b1;
        bus.o_ram_addr  = bus.i_ld_addr;
        bus.o_ram_wr    = bus.i_ld_wr;
        bus.o_ram_wdata = bus.i_ld_wdata;
      end
      PORT_D: begin
        bus.o_ram_en    = 1'b1;
        bus.o_ram_addr  = bus.i_d_addr;
        bus.o_ram_wr    = bus.i_d_wr;
        bus.o_ram_wdata = bus.i_d_wdata;
      end
      PORT_I: begin
        bus.o_ram_en    = 1'b1;
        bus.o_ram_addr  = bus.i_i_addr;
      end
      default: ;
    endcase
  end

  // Grant/ack tracking FSM with registered ack outputs. Any grant moves to
  // (or stays in) ST_ACK with the granted port recorded; otherwise IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      ack_port  <= PORT_NONE;
      rr_last_i <= 1'b1;
      ld_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      i_ack_q   <= 1'b0;
    end else begin
      ld_ack_q <= (grant == PORT_L);
      d_ack_q  <= (grant == PORT_D);
      i_ack_q  <= (grant == PORT_I);
      case (state)
        ST_IDLE: begin
          if (grant != PORT_NONE) begin
            state    <= ST_ACK;
            ack_port <= grant;
          end
        end
        ST_ACK: begin
          if (grant != PORT_NONE) begin
            state    <= ST_ACK;
            ack_port <= grant;
          end else begin
            state    <= ST_IDLE;
            ack_port <= PORT_NONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ack_port <= PORT_NONE;
        end
      endcase
      // Loader grants leave the D/I round-robin pointer alone.
      if (grant == PORT_D)
        rr_last_i <= 1'b0;
      else if (grant == PORT_I)
        rr_last_i <= 1'b1;
    end
  end

  always_comb begin
    bus.o_ld_ack   = ld_ack_q;
    bus.o_d_ack    = d_ack_q;
    bus.o_i_ack    = i_ack_q;
    bus.o_ld_rdata = ld_ack_q ? bus.i_ram_rdata : '0;
    bus.o_d_rdata  = d_ack_q  ? bus.i_ram_rdata : '0;
    bus.o_i_rdata  = i_ack_q  ? bus.i_ram_rdata : '0;
    bus.o_busy     = bus.o_ram_en || (state == ST_ACK);
    o_dbg_state    = state;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam logic [1:0] P_L = 2'd1;
  localparam logic [1:0] P_D = 2'd2;
  localparam logic [1:0] P_I = 2'd3;

  logic i_clk;
  logic i_rst;
  logic o_dbg_state;
  int   checks;
  int   failures;

  logic [DW-1:0]   ram     [0:(1<<AW)-1];
  logic [DW-1:0]   ref_mem [0:(1<<AW)-1];
  logic [DW+1:0]   exp_q[$];   // {port, expected rdata}
  logic [DW+1:0]   e;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus.slave),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5)  return 32'hDEADBEEF;
    if (a == 16) return 32'h11223344;
    return 32'hC0DE0000 ^ (a * 32'h00010101);
  endfunction

  // Synchronous single-port RAM model, read-before-write.
  initial begin
    logic [DW-1:0] w;
    for (int i = 0; i < (1<<AW); i++) ram[i] = init_word(i);
    bus.i_ram_rdata = '0;
    forever begin
      @(posedge i_clk);
      if (bus.o_ram_en) begin
        w = ram[bus.o_ram_addr];
        bus.i_ram_rdata <= w;
        for (int b = 0; b < DW/8; b++)
          if (bus.o_ram_wr[b]) w[b*8 +: 8] = bus.o_ram_wdata[b*8 +: 8];
        ram[bus.o_ram_addr] = w;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] p, input logic [AW-1:0] a,
                           input logic [DW/8-1:0] w, input logic [DW-1:0] d);
    case (p)
      P_L: begin bus.i_ld_req = 1'b1; bus.i_ld_addr = a; bus.i_ld_wr = w; bus.i_ld_wdata = d; end
      P_D: begin bus.i_d_req = 1'b1; bus.i_d_addr = a; bus.i_d_wr = w; bus.i_d_wdata = d; end
      default: begin bus.i_i_req = 1'b1; bus.i_i_addr = a; end
    endcase
  endtask

  task automatic drop_req(input logic [1:0] p);
    case (p)
      P_L: bus.i_ld_req = 1'b0;
      P_D: bus.i_d_req = 1'b0;
      default: bus.i_i_req = 1'b0;
    endcase
  endtask

  // Scoreboard push at grant: the ack returns the pre-write word.
  task automatic push_exp(input logic [1:0] p, input logic [AW-1:0] a,
                          input logic [DW/8-1:0] w, input logic [DW-1:0] d);
    exp_q.push_back({p, ref_mem[a]});
    for (int b = 0; b < DW/8; b++)
      if (w[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic pop_exp(output logic [DW+1:0] v);
    if (exp_q.size() == 0) v = '1;
    else v = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b0;
    bus.i_d_req = 1'b1;
    bus.i_d_addr = 13'h005;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({bus.o_ld_ack, bus.o_d_ack, bus.o_i_ack} !== 3'b000) begin
      failures++; $display("FAIL reset_acks got=%b want=000", {bus.o_ld_ack, bus.o_d_ack, bus.o_i_ack});
    end
    checks++;
    if (bus.o_ram_en !== 1'b0 || bus.o_ram_wr !== 4'h0 || bus.o_busy !== 1'b0) begin
      failures++; $display("FAIL reset_ram got en=%b wr=%h busy=%b want 0/0/0", bus.o_ram_en, bus.o_ram_wr, bus.o_busy);
    end
    checks++;
    if ({bus.o_ld_rdata, bus.o_d_rdata, bus.o_i_rdata} !== '0 || o_dbg_state !== 1'b0) begin
      failures++; $display("FAIL reset_rdata_state got d=%h state=%b want 0", bus.o_d_rdata, o_dbg_state);
    end
    bus.i_d_req = 1'b0;
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b0 || o_dbg_state !== 1'b0 || bus.o_d_ack !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got en=%b state=%b ack=%b want 0", bus.o_ram_en, o_dbg_state, bus.o_d_ack);
    end
  endtask

  task automatic test_contention();
    logic [1:0]    gp;
    logic [AW-1:0] ga;
    step();
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    drive_req(P_D, 13'h020, 4'h0, 32'h0);
    drive_req(P_I, 13'h021, 4'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      gp = (c % 2 == 0) ? P_D : P_I;
      ga = (c % 2 == 0) ? 13'h020 : 13'h021;
      checks++;
      if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== ga || bus.o_ram_wr !== 4'h0) begin
        failures++; $display("FAIL contention_grant c=%0d got en=%b addr=%h wr=%h want addr=%h", c, bus.o_ram_en, bus.o_ram_addr, bus.o_ram_wr, ga);
      end
      if (c > 0) begin
        pop_exp(e);
        checks++;
        if (gp == P_I) begin
          if (bus.o_d_ack !== 1'b1 || bus.o_i_ack !== 1'b0 || e !== {P_D, bus.o_d_rdata}) begin
            failures++; $display("FAIL contention_ack_d c=%0d got ack=%b%b rdata=%h want %h", c, bus.o_d_ack, bus.o_i_ack, bus.o_d_rdata, e[DW-1:0]);
          end
        end else begin
          if (bus.o_i_ack !== 1'b1 || bus.o_d_ack !== 1'b0 || e !== {P_I, bus.o_i_rdata}) begin
            failures++; $display("FAIL contention_ack_i c=%0d got ack=%b%b rdata=%h want %h", c, bus.o_d_ack, bus.o_i_ack, bus.o_i_rdata, e[DW-1:0]);
          end
        end
      end
      push_exp(gp, ga, 4'h0, 32'h0);
      @(posedge i_clk);
    end
    #1;
    drop_req(P_D);
    drop_req(P_I);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_i_ack !== 1'b1 || bus.o_ram_en !== 1'b0 || e !== {P_I, bus.o_i_rdata}) begin
      failures++; $display("FAIL contention_last got ack=%b en=%b rdata=%h want ack=1 en=0 rdata=%h", bus.o_i_ack, bus.o_ram_en, bus.o_i_rdata, e[DW-1:0]);
    end
  endtask

  task automatic test_loader();
    step();
    bus.i_ld_hold = 1'b1;
    drive_req(P_L, 13'h000, 4'hF, 32'h12345678);
    drive_req(P_D, 13'h005, 4'h0, 32'h0);
    drive_req(P_I, 13'h006, 4'h0, 32'h0);
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 13'h000 || bus.o_ram_wr !== 4'hF || bus.o_ram_wdata !== 32'h12345678) begin
      failures++; $display("FAIL loader_grant got addr=%h wr=%h wdata=%h want 000/F/12345678", bus.o_ram_addr, bus.o_ram_wr, bus.o_ram_wdata);
    end
    push_exp(P_L, 13'h000, 4'hF, 32'h12345678);
    step();
    drop_req(P_L);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_ld_ack !== 1'b1 || bus.o_ram_en !== 1'b0 || bus.o_d_ack !== 1'b0 || bus.o_i_ack !== 1'b0 || e !== {P_L, bus.o_ld_rdata}) begin
      failures++; $display("FAIL loader_ack got l=%b en=%b d=%b i=%b rdata=%h want 1/0/0/0 %h", bus.o_ld_ack, bus.o_ram_en, bus.o_d_ack, bus.o_i_ack, bus.o_ld_rdata, e[DW-1:0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++;
      if (bus.o_ram_en !== 1'b0 || bus.o_d_ack !== 1'b0 || bus.o_i_ack !== 1'b0) begin
        failures++; $display("FAIL loader_hold c=%0d got en=%b d=%b i=%b want 0", c, bus.o_ram_en, bus.o_d_ack, bus.o_i_ack);
      end
    end
    step();
    bus.i_ld_hold = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 13'h005) begin
      failures++; $display("FAIL hold_release_d got en=%b addr=%h want 1/005", bus.o_ram_en, bus.o_ram_addr);
    end
    push_exp(P_D, 13'h005, 4'h0, 32'h0);
    step();
    drop_req(P_D);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_d_ack !== 1'b1 || e !== {P_D, bus.o_d_rdata} || bus.o_ram_addr !== 13'h006) begin
      failures++; $display("FAIL hold_d_ack got ack=%b rdata=%h addr=%h want 1 %h 006", bus.o_d_ack, bus.o_d_rdata, bus.o_ram_addr, e[DW-1:0]);
    end
    push_exp(P_I, 13'h006, 4'h0, 32'h0);
    step();
    drop_req(P_I);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_i_ack !== 1'b1 || e !== {P_I, bus.o_i_rdata} || bus.o_ram_en !== 1'b0) begin
      failures++; $display("FAIL hold_i_ack got ack=%b rdata=%h en=%b want 1 %h 0", bus.o_i_ack, bus.o_i_rdata, bus.o_ram_en, e[DW-1:0]);
    end
  endtask

  // D access; checks the grant and the ack cycle, then one idle cycle.
  task automatic test_d_access(input logic [AW-1:0] a, input logic [3:0] w,
                               input logic [DW-1:0] d, input logic [DW-1:0] want);
    step();
    drive_req(P_D, a, w, d);
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== a || bus.o_ram_wr !== w || bus.o_busy !== 1'b1 || bus.o_d_ack !== 1'b0) begin
      failures++; $display("FAIL d_grant got en=%b addr=%h wr=%h busy=%b ack=%b want 1 %h %h 1 0", bus.o_ram_en, bus.o_ram_addr, bus.o_ram_wr, bus.o_busy, bus.o_d_ack, a, w);
    end
    push_exp(P_D, a, w, d);
    step();
    drop_req(P_D);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_d_ack !== 1'b1 || e !== {P_D, bus.o_d_rdata} || bus.o_d_rdata !== bus.i_ram_rdata || bus.o_d_rdata !== want) begin
      failures++; $display("FAIL d_ack got ack=%b rdata=%h want 1 %h", bus.o_d_ack, bus.o_d_rdata, want);
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_d_ack !== 1'b0 || bus.o_d_rdata !== '0 || bus.o_ram_en !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++; $display("FAIL d_after got ack=%b rdata=%h en=%b busy=%b want 0", bus.o_d_ack, bus.o_d_rdata, bus.o_ram_en, bus.o_busy);
    end
  endtask

  task automatic test_single_read();
    test_d_access(13'h005, 4'h0, 32'h0, 32'hDEADBEEF);
    test_d_access(13'h000, 4'h0, 32'h0, 32'h12345678);
  endtask

  task automatic test_byte_write();
    test_d_access(13'h010, 4'b0010, 32'h0000AB00, 32'h11223344);
    test_d_access(13'h010, 4'h0, 32'h0, 32'h1122AB44);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    a = AW'($urandom_range(32, 8000));
    step();
    drive_req(P_I, a, 4'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      checks++;
      if (c % 2 == 0) begin
        if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== a || bus.o_ram_wr !== 4'h0 || bus.o_i_ack !== 1'b0) begin
          failures++; $display("FAIL repeat_grant c=%0d got en=%b addr=%h ack=%b want 1 %h 0", c, bus.o_ram_en, bus.o_ram_addr, bus.o_i_ack, a);
        end
        push_exp(P_I, a, 4'h0, 32'h0);
      end else begin
        pop_exp(e);
        if (bus.o_ram_en !== 1'b0 || bus.o_i_ack !== 1'b1 || e !== {P_I, bus.o_i_rdata}) begin
          failures++; $display("FAIL repeat_ack c=%0d got en=%b ack=%b rdata=%h want 0 1 %h", c, bus.o_ram_en, bus.o_i_ack, bus.o_i_rdata, e[DW-1:0]);
        end
      end
    end
    step();
    drop_req(P_I);
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b0 || bus.o_i_ack !== 1'b0) begin
      failures++; $display("FAIL repeat_stop got en=%b ack=%b want 0 0", bus.o_ram_en, bus.o_i_ack);
    end
  endtask

  task automatic test_reset_mid();
    step();
    drive_req(P_D, 13'h005, 4'h0, 32'h0);
    @(negedge i_clk);
    checks++;
    if (bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 13'h005) begin
      failures++; $display("FAIL rstmid_grant got en=%b addr=%h want 1 005", bus.o_ram_en, bus.o_ram_addr);
    end
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_d_ack !== 1'b0 || bus.o_ram_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_d_rdata !== '0) begin
      failures++; $display("FAIL rstmid_drop got ack=%b en=%b busy=%b rdata=%h want 0", bus.o_d_ack, bus.o_ram_en, bus.o_busy, bus.o_d_rdata);
    end
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_d_ack !== 1'b0 || bus.o_ram_en !== 1'b1 || bus.o_ram_addr !== 13'h005) begin
      failures++; $display("FAIL rstmid_regrant got ack=%b en=%b addr=%h want 0 1 005", bus.o_d_ack, bus.o_ram_en, bus.o_ram_addr);
    end
    push_exp(P_D, 13'h005, 4'h0, 32'h0);
    step();
    drop_req(P_D);
    @(negedge i_clk);
    pop_exp(e);
    checks++;
    if (bus.o_d_ack !== 1'b1 || e !== {P_D, bus.o_d_rdata} || bus.o_d_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rstmid_ack got ack=%b rdata=%h want 1 deadbeef", bus.o_d_ack, bus.o_d_rdata);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
    i_rst = 1'b0;
    bus.i_ld_req = 1'b0; bus.i_ld_addr = '0; bus.i_ld_wr = '0; bus.i_ld_wdata = '0;
    bus.i_d_req = 1'b0;  bus.i_d_addr = '0;  bus.i_d_wr = '0;  bus.i_d_wdata = '0;
    bus.i_i_req = 1'b0;  bus.i_i_addr = '0;
    bus.i_ld_hold = 1'b0;

    test_reset();
    test_contention();
    test_loader();
    test_single_read();
    test_byte_write();
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
